load_store_unit: RTL and testbench

Multi-cycle load/store unit sitting directly downstream of the execute stage. It takes the ALU-computed effective address, the rs2 store data and the funct3 size code, and drives a valid/ready data-memory bus with word-aligned addresses and byte enables. It returns sign- or zero-extended load data and the destination register to writeback. Misaligned, illegal and timed-out accesses are reported as errors instead of reaching or hanging the bus.

---
 rtl/lsu_pkg.sv | 50 +++++
 rtl/lsu_if.sv | 21 ++
 rtl/lsu_load_align.sv | 29 ++
 rtl/load_store_unit.sv | 124 ++++++++++++
 tb/tb_load_store_unit.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared types and decode helpers for the load/store unit: state encoding,
// funct3 size codes, byte-enable and store-lane generation, legality checks.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic [3:0] be_for(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3)
      F3_B:    be_for = 4'b0001 << addr_lo;
      F3_H:    be_for = 4'b0011 << {addr_lo[1], 1'b0};
      F3_W:    be_for = 4'b1111;
      default: be_for = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] funct3, input logic [31:0] data);
    case (funct3)
      F3_B:    store_lanes = {4{data[7:0]}};
      F3_H:    store_lanes = {2{data[15:0]}};
      default: store_lanes = data;
    endcase
  endfunction

  // Stores only have the signed size codes; loads add the unsigned variants.
  function automatic logic is_legal(input logic we, input logic [2:0] funct3);
    if (we) is_legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    else    is_legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                       (funct3 == F3_BU) || (funct3 == F3_HU);
  endfunction

  function automatic logic is_aligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3[1:0])
      2'b10:   is_aligned = (addr_lo == 2'b00);
      2'b01:   is_aligned = ~addr_lo[0];
      default: is_aligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Data-memory valid/ready bus between the LSU (master) and memory (slave).
interface lsu_mem_if;
  logic        mem_valid;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ready, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/lsu_load_align.sv
// Extracts the addressed byte/half from a load word and sign- or zero-extends
// it according to funct3; purely combinational.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [31:0] shifted;

  assign shifted = rdata >> {addr_lo, 3'b000};

  always_comb begin
    // NOTE: default assignment first so no path through the case leaves data unassigned (no latch).
    data = 32'h0;
    case (funct3)
      F3_B:    data = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
      F3_W:    data = rdata;
      F3_BU:   data = {24'h0, shifted[7:0]};
      F3_HU:   data = {16'h0, shifted[15:0]};
      default: data = 32'h0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: captures an execute-stage access, runs it over
// the valid/ready memory bus with a timeout, and returns one response pulse.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        resp_valid,
  output logic        resp_wb,
  output logic [4:0]  resp_rd,
  output logic [31:0] resp_data,
  output logic        resp_err,
  lsu_mem_if.master   mem
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  lsu_state_t  state;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic [4:0]  rd_q;
  logic [7:0]  cnt_q;
  logic [31:0] data_q;
  logic        err_q;
  logic        wb_q;
  logic [31:0] load_data;

  lsu_load_align u_align (
    .funct3  (funct3_q),
    .addr_lo (addr_q[1:0]),
    .rdata   (mem.mem_rdata),
    .data    (load_data)
  );

  // Bus and response outputs come from registers gated by state only, so
  // nothing on the mem_* inputs reaches the mem_* outputs combinationally.
  assign req_ready      = (state == IDLE);
  assign mem.mem_valid  = (state == REQ);
  assign mem.mem_we     = (state == REQ) & we_q;
  assign mem.mem_be     = (state == REQ) ? be_q : 4'b0000;
  assign mem.mem_addr   = {addr_q[31:2], 2'b00};
  assign mem.mem_wdata  = wdata_q;
  assign resp_valid     = (state == RESP);
  assign resp_wb        = (state == RESP) & wb_q;
  assign resp_err       = (state == RESP) & err_q;
  assign resp_data      = (state == RESP) ? data_q : 32'h0;
  assign resp_rd        = rd_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      be_q     <= 4'b0000;
      rd_q     <= 5'd0;
      cnt_q    <= 8'd0;
      data_q   <= 32'h0;
      err_q    <= 1'b0;
      wb_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q     <= req_we;
            funct3_q <= req_funct3;
            addr_q   <= req_addr;
            wdata_q  <= store_lanes(req_funct3, req_wdata);
            be_q     <= req_we ? be_for(req_funct3, req_addr[1:0]) : 4'b0000;
            rd_q     <= req_rd;
            cnt_q    <= 8'd0;
            data_q   <= 32'h0;
            wb_q     <= 1'b0;
            if (is_legal(req_we, req_funct3) && is_aligned(req_funct3, req_addr[1:0])) begin
              err_q <= 1'b0;
              state <= REQ;
            end else begin
              err_q <= 1'b1;
              state <= RESP;
            end
          end
        end
        REQ: begin
          cnt_q <= cnt_q + 8'd1;
          if (mem.mem_ready) begin
            state <= we_q ? RESP : WAIT;
          end else if (cnt_q == CNT_LAST) begin
            err_q <= 1'b1;
            state <= RESP;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q + 8'd1;
          if (mem.mem_rvalid) begin
            data_q <= load_data;
            wb_q   <= (rd_q != 5'd0);
            state  <= RESP;
          end else if (cnt_q >= CNT_LAST) begin
            // A load accepted on the last REQ cycle still aborts here.
            err_q <= 1'b1;
            state <= RESP;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed, table-driven bench for load_store_unit with a small bus responder
// driven per vector, plus hand sequences for stray rvalid and mid-access reset.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        resp_valid;
  logic        resp_wb;
  logic [4:0]  resp_rd;
  logic [31:0] resp_data;
  logic        resp_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  lsu_mem_if mem_bus ();

  load_store_unit #(.TIMEOUT(8)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_rd     (req_rd),
    .resp_valid (resp_valid),
    .resp_wb    (resp_wb),
    .resp_rd    (resp_rd),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .mem        (mem_bus)
  );

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [4:0]  rd;
    int          ready_dly;
    bit          rv_en;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] e_data;
    bit          e_wb;
    bit          e_err;
    bit          e_mem;
    int          e_lat;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata, input logic [4:0] rd,
                              input int dly, input bit rv_en, input logic [31:0] e_addr,
                              input logic [3:0] e_be, input logic [31:0] e_wdata,
                              input logic [31:0] e_data, input bit e_wb, input bit e_err,
                              input bit e_mem, input int e_lat);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.rd = rd;
    v.ready_dly = dly; v.rv_en = rv_en; v.e_addr = e_addr; v.e_be = e_be; v.e_wdata = e_wdata;
    v.e_data = e_data; v.e_wb = e_wb; v.e_err = e_err; v.e_mem = e_mem; v.e_lat = e_lat;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    int    cyc;
    bit    got, saw, acc, rdy, prev_valid;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    check({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_we     = v.we;
    req_funct3 = v.f3;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    req_rd     = v.rd;
    mem_bus.mem_rdata = v.rdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    got = 0; saw = 0; acc = 0; rdy = 0; prev_valid = 0;
    cyc = 0;
    while (!got && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (rdy && prev_valid) acc = 1;
      if (mem_bus.mem_valid) begin
        if (!saw) check({tag, ".first_mem_cycle"}, 32'(cyc), 32'd1);
        saw = 1;
        check({tag, ".mem_addr"}, mem_bus.mem_addr, v.e_addr);
        check({tag, ".mem_be"}, 32'(mem_bus.mem_be), 32'(v.e_be));
        check({tag, ".mem_wdata"}, mem_bus.mem_wdata, v.e_wdata);
        check({tag, ".mem_we"}, 32'(mem_bus.mem_we), 32'(v.we));
      end
      prev_valid = mem_bus.mem_valid;
      rdy = mem_bus.mem_valid && (cyc - 1 >= v.ready_dly);
      mem_bus.mem_ready  = rdy;
      mem_bus.mem_rvalid = acc && v.rv_en && !v.we;
      if (resp_valid) begin
        got = 1;
        check({tag, ".resp_cycle"}, 32'(cyc), 32'(v.e_lat));
        check({tag, ".resp_data"}, resp_data, v.e_data);
        check({tag, ".resp_err"}, 32'(resp_err), 32'(v.e_err));
        check({tag, ".resp_wb"}, 32'(resp_wb), 32'(v.e_wb));
        check({tag, ".resp_rd"}, 32'(resp_rd), 32'(v.rd));
        check({tag, ".mem_valid_in_resp"}, 32'(mem_bus.mem_valid), 32'd0);
      end
    end
    mem_bus.mem_ready  = 1'b0;
    mem_bus.mem_rvalid = 1'b0;
    check({tag, ".resp_seen"}, 32'(got), 32'd1);
    check({tag, ".bus_used"}, 32'(saw), 32'(v.e_mem));
    @(negedge clk);
    check({tag, ".ready_after_resp"}, 32'(req_ready), 32'd1);
    check({tag, ".single_pulse"}, 32'(resp_valid), 32'd0);
  endtask

  initial begin
    vecs[0]  = mk(0, F3_W,  32'h1004, 32'h0, 32'hDEADBEEF, 5'd5,  0, 1, 32'h1004, 4'h0, 32'h0, 32'hDEADBEEF, 1, 0, 1, 3);
    vecs[1]  = mk(0, F3_B,  32'h1003, 32'h0, 32'h80FF0000, 5'd6,  0, 1, 32'h1000, 4'h0, 32'h0, 32'hFFFFFF80, 1, 0, 1, 3);
    vecs[2]  = mk(0, F3_BU, 32'h1003, 32'h0, 32'h80FF0000, 5'd6,  0, 1, 32'h1000, 4'h0, 32'h0, 32'h00000080, 1, 0, 1, 3);
    vecs[3]  = mk(0, F3_H,  32'h1002, 32'h0, 32'h80FF0000, 5'd7,  0, 1, 32'h1000, 4'h0, 32'h0, 32'hFFFF80FF, 1, 0, 1, 3);
    vecs[4]  = mk(0, F3_HU, 32'h1002, 32'h0, 32'h80FF0000, 5'd7,  0, 1, 32'h1000, 4'h0, 32'h0, 32'h000080FF, 1, 0, 1, 3);
    vecs[5]  = mk(0, F3_B,  32'h1001, 32'h0, 32'h12345678, 5'd8,  0, 1, 32'h1000, 4'h0, 32'h0, 32'h00000056, 1, 0, 1, 3);
    vecs[6]  = mk(1, F3_H,  32'h2002, 32'h1234ABCD, 32'h0, 5'd9,  3, 0, 32'h2000, 4'hC, 32'hABCDABCD, 32'h0, 0, 0, 1, 5);
    vecs[7]  = mk(1, F3_B,  32'h3001, 32'h000000A5, 32'h0, 5'd10, 0, 0, 32'h3000, 4'h2, 32'hA5A5A5A5, 32'h0, 0, 0, 1, 2);
    vecs[8]  = mk(1, F3_W,  32'h3000, 32'hCAFEF00D, 32'h0, 5'd11, 1, 0, 32'h3000, 4'hF, 32'hCAFEF00D, 32'h0, 0, 0, 1, 3);
    vecs[9]  = mk(0, F3_W,  32'h1001, 32'h0, 32'h0, 5'd12, 0, 1, 32'h0, 4'h0, 32'h0, 32'h0, 0, 1, 0, 1);
    vecs[10] = mk(0, 3'b011, 32'h1000, 32'h0, 32'h0, 5'd12, 0, 1, 32'h0, 4'h0, 32'h0, 32'h0, 0, 1, 0, 1);
    vecs[11] = mk(1, F3_H,  32'h2001, 32'h5555, 32'h0, 5'd1, 0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 0, 1, 0, 1);
    vecs[12] = mk(1, 3'b100, 32'h2000, 32'h5555, 32'h0, 5'd1, 0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 0, 1, 0, 1);
    vecs[13] = mk(0, F3_B,  32'h1000, 32'h0, 32'h000000FF, 5'd0, 0, 1, 32'h1000, 4'h0, 32'h0, 32'hFFFFFFFF, 0, 0, 1, 3);
    vecs[14] = mk(0, F3_W,  32'h1000, 32'h0, 32'h0, 5'd12, 0, 0, 32'h1000, 4'h0, 32'h0, 32'h0, 0, 1, 1, 9);
    vecs[15] = mk(1, F3_W,  32'h4000, 32'h11111111, 32'h0, 5'd13, 99, 0, 32'h4000, 4'hF, 32'h11111111, 32'h0, 0, 1, 1, 9);

    n_rst = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0;
    mem_bus.mem_ready = 1'b0; mem_bus.mem_rvalid = 1'b0; mem_bus.mem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    check("rst.req_ready", 32'(req_ready), 32'd1);
    check("rst.mem_valid", 32'(mem_bus.mem_valid), 32'd0);
    check("rst.mem_addr", mem_bus.mem_addr, 32'h0);
    check("rst.mem_be", 32'(mem_bus.mem_be), 32'h0);
    check("rst.resp_valid", 32'(resp_valid), 32'd0);
    check("rst.resp_data", resp_data, 32'h0);
    n_rst = 1'b1;

    for (int i = 0; i < 16; i++) run_vec(vecs[i], i);

    // Stray rvalid while idle must not produce a response.
    mem_bus.mem_rdata = 32'hFFFFFFFF;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      mem_bus.mem_rvalid = 1'b1;
      check($sformatf("stray.resp_valid%0d", k), 32'(resp_valid), 32'd0);
      check($sformatf("stray.req_ready%0d", k), 32'(req_ready), 32'd1);
    end
    mem_bus.mem_rvalid = 1'b0;

    // Reset while the load sits in WAIT.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3_W; req_addr = 32'h5000; req_rd = 5'd3;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("rstw.mem_valid_c1", 32'(mem_bus.mem_valid), 32'd1);
    mem_bus.mem_ready = 1'b1;
    @(negedge clk);
    mem_bus.mem_ready = 1'b0;
    check("rstw.in_wait", 32'(mem_bus.mem_valid | req_ready | resp_valid), 32'd0);
    @(negedge clk);
    n_rst = 1'b0;
    #1;
    check("rstw.mem_valid", 32'(mem_bus.mem_valid), 32'd0);
    check("rstw.resp_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    mem_bus.mem_rvalid = 1'b1;
    @(negedge clk);
    mem_bus.mem_rvalid = 1'b0;
    check("rstw.req_ready", 32'(req_ready), 32'd1);
    check("rstw.no_resp", 32'(resp_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
